// File: rtl/frame_color_stats.sv
// Per-frame colour analyser: counts TARGET-coloured pixels and their bounding box on the capture write stream.
// Optional per-colour histogram output enabled by defining FRAME_COLOR_STATS_HIST_EN.
module frame_color_stats #(
    parameter int unsigned    AW        = 15,
    parameter int unsigned    DW        = 3,
    parameter int unsigned    WIDTH     = 160,
    parameter int unsigned    HEIGHT    = 120,
    parameter logic [DW-1:0]  TARGET    = 3'b100,
    parameter int unsigned    MIN_COUNT = 200
) (
    input  logic          PCLK,
    input  logic          rst,
    input  logic          VSYNC,
    input  logic [AW-1:0] mem_px_addr,
    input  logic [DW-1:0] mem_px_data,
    input  logic          px_wr,
    output logic [AW-1:0] match_count,
    output logic [7:0]    x_min,
    output logic [7:0]    x_max,
    output logic [6:0]    y_min,
    output logic [6:0]    y_max,
    output logic          detected,
    output logic          result_valid,
    output logic          frame_err
`ifdef FRAME_COLOR_STATS_HIST_EN
    ,
    output logic [8*AW-1:0] hist
`endif
);

    localparam int unsigned   NPIX      = WIDTH * HEIGHT;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [7:0]    X_LAST    = 8'(WIDTH - 1);
    localparam logic [6:0]    Y_LAST    = 7'(HEIGHT - 1);
    localparam logic [AW-1:0] CNT_MAX   = '1;
    localparam logic [AW-1:0] MIN_CNT   = AW'(MIN_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        PUBLISH
    } state_t;

    state_t        state;
    logic          px_wr_d;
    logic          vsync_d;
    logic [7:0]    x_cnt;
    logic [6:0]    y_cnt;
    logic [AW-1:0] acc_cnt;
    logic [7:0]    acc_x_min;
    logic [7:0]    acc_x_max;
    logic [6:0]    acc_y_min;
    logic [6:0]    acc_y_max;
`ifdef FRAME_COLOR_STATS_HIST_EN
    logic [AW-1:0] acc_bin [8];
`endif

    logic accept;
    logic hit;
    logic eof;
    logic vs_fall;
    logic vs_rise;

    // A write is taken only on the rising edge of the registered strobe.
    assign accept  = px_wr & ~px_wr_d;
    assign hit     = accept && (mem_px_data == TARGET);
    assign eof     = accept && (((x_cnt == X_LAST) && (y_cnt == Y_LAST)) || (mem_px_addr == LAST_ADDR));
    assign vs_fall = vsync_d & ~VSYNC;
    assign vs_rise = VSYNC & ~vsync_d;

    always_ff @(posedge PCLK or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            px_wr_d      <= 1'b0;
            vsync_d      <= 1'b0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            acc_cnt      <= '0;
            acc_x_min    <= X_LAST;
            acc_x_max    <= '0;
            acc_y_min    <= Y_LAST;
            acc_y_max    <= '0;
            match_count  <= '0;
            x_min        <= X_LAST;
            x_max        <= '0;
            y_min        <= Y_LAST;
            y_max        <= '0;
            detected     <= 1'b0;
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
`ifdef FRAME_COLOR_STATS_HIST_EN
            hist         <= '0;
            for (int k = 0; k < 8; k++) acc_bin[k] <= '0;
`endif
        end else begin
            px_wr_d      <= px_wr;
            vsync_d      <= VSYNC;
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_fall) begin
                        x_cnt     <= '0;
                        y_cnt     <= '0;
                        acc_cnt   <= '0;
                        acc_x_min <= X_LAST;
                        acc_x_max <= '0;
                        acc_y_min <= Y_LAST;
                        acc_y_max <= '0;
`ifdef FRAME_COLOR_STATS_HIST_EN
                        for (int k = 0; k < 8; k++) acc_bin[k] <= '0;
`endif
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (hit) begin
                            if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + AW'(1);
                            if (x_cnt < acc_x_min) acc_x_min <= x_cnt;
                            if (x_cnt > acc_x_max) acc_x_max <= x_cnt;
                            if (y_cnt < acc_y_min) acc_y_min <= y_cnt;
                            if (y_cnt > acc_y_max) acc_y_max <= y_cnt;
                        end
`ifdef FRAME_COLOR_STATS_HIST_EN
                        acc_bin[mem_px_data] <= acc_bin[mem_px_data] + AW'(1);
`endif
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + 7'd1;
                        end else begin
                            x_cnt <= x_cnt + 8'd1;
                        end
                    end
                    // The final pixel wins over a coincident VSYNC rise.
                    if (eof) begin
                        state <= PUBLISH;
                    end else if (vs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                PUBLISH: begin
                    match_count  <= acc_cnt;
                    x_min        <= acc_x_min;
                    x_max        <= acc_x_max;
                    y_min        <= acc_y_min;
                    y_max        <= acc_y_max;
                    detected     <= (acc_cnt >= MIN_CNT);
                    result_valid <= 1'b1;
`ifdef FRAME_COLOR_STATS_HIST_EN
                    for (int k = 0; k < 8; k++) hist[k*AW +: AW] <= acc_bin[k];
`endif
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_color_stats.sv
// Scoreboard bench for frame_color_stats: per-frame expectations are queued while driving and checked on result_valid.
module tb_frame_color_stats;

    logic        PCLK;
    logic        rst;
    logic        VSYNC;
    logic [14:0] mem_px_addr;
    logic [2:0]  mem_px_data;
    logic        px_wr;
    logic [14:0] match_count;
    logic [7:0]  x_min;
    logic [7:0]  x_max;
    logic [6:0]  y_min;
    logic [6:0]  y_max;
    logic        detected;
    logic        result_valid;
    logic        frame_err;
`ifdef FRAME_COLOR_STATS_HIST_EN
    logic [119:0] hist;
`endif

    frame_color_stats dut (
        .PCLK         (PCLK),
        .rst          (rst),
        .VSYNC        (VSYNC),
        .mem_px_addr  (mem_px_addr),
        .mem_px_data  (mem_px_data),
        .px_wr        (px_wr),
        .match_count  (match_count),
        .x_min        (x_min),
        .x_max        (x_max),
        .y_min        (y_min),
        .y_max        (y_max),
        .detected     (detected),
        .result_valid (result_valid),
        .frame_err    (frame_err)
`ifdef FRAME_COLOR_STATS_HIST_EN
        ,
        .hist         (hist)
`endif
    );

    typedef struct {
        int cnt;
        int xmn;
        int xmx;
        int ymn;
        int ymx;
        int det;
        int cyc;
`ifdef FRAME_COLOR_STATS_HIST_EN
        logic [119:0] hb;
`endif
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_valid = 0;
    int   n_err   = 0;
    int   cyc     = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_count"}, 32'(match_count), 32'd0);
        chk({tag, "_xmin"},  32'(x_min), 32'd159);
        chk({tag, "_xmax"},  32'(x_max), 32'd0);
        chk({tag, "_ymin"},  32'(y_min), 32'd119);
        chk({tag, "_ymax"},  32'(y_max), 32'd0);
        chk({tag, "_det"},   32'(detected), 32'd0);
        chk({tag, "_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_err"},   32'(frame_err), 32'd0);
    endtask

    function automatic logic [2:0] px_color(input int kind, input int i);
        int x;
        int y;
        x = i % 160;
        y = i / 160;
        case (kind)
            1: px_color = (x >= 40 && x <= 59 && y >= 30 && y <= 44) ? 3'b100 : 3'b000;
            2: px_color = (i < 200) ? 3'b100 : 3'b000;
            3: px_color = (i < 199) ? 3'b100 : 3'b000;
            4: begin
                if (i % 37 == 0)     px_color = 3'b100;
                else if (i % 5 == 1) px_color = 3'b110;
                else if (i % 7 == 2) px_color = 3'b001;
                else                 px_color = 3'b000;
            end
            default: px_color = 3'b000;
        endcase
    endfunction

    task automatic send_px(input logic [14:0] a, input logic [2:0] d, input int hold);
        mem_px_addr = a;
        mem_px_data = d;
        px_wr       = 1'b1;
        repeat (hold) @(posedge PCLK);
        #1;
        px_wr = 1'b0;
        tick();
    endtask

    task automatic start_frame();
        VSYNC = 1'b1;
        repeat (3) tick();
        VSYNC = 1'b0;
        repeat (2) tick();
    endtask

    // Drives n pixels; the model tracks position from the pixel index, independent of the DUT.
    task automatic run_frame(input int n, input int kind, input int hold,
                             input bit vs_last, input bit term, input bit pub);
        exp_t        e;
        int          hb[8];
        logic [2:0]  d;
        logic [14:0] a;
        int          x;
        int          y;
        e.cnt = 0; e.xmn = 159; e.xmx = 0; e.ymn = 119; e.ymx = 0; e.det = 0; e.cyc = 0;
        for (int k = 0; k < 8; k++) hb[k] = 0;
        for (int i = 0; i < n; i++) begin
            d = px_color(kind, i);
            x = i % 160;
            y = i / 160;
            if (d == 3'b100) begin
                e.cnt++;
                if (x < e.xmn) e.xmn = x;
                if (x > e.xmx) e.xmx = x;
                if (y < e.ymn) e.ymn = y;
                if (y > e.ymx) e.ymx = y;
            end
            hb[int'(d)]++;
            a = (term && i == n - 1) ? 15'd19199 : 15'(i);
            if (i == n - 1) begin
                if (pub) begin
                    e.det = (e.cnt >= 200) ? 1 : 0;
                    e.cyc = cyc + 2;
`ifdef FRAME_COLOR_STATS_HIST_EN
                    for (int k = 0; k < 8; k++) e.hb[k*15 +: 15] = 15'(hb[k]);
`endif
                    sb.push_back(e);
                    last_e = e;
                end
                if (vs_last) VSYNC = 1'b1;
            end
            send_px(a, d, hold);
        end
    endtask

    // Output monitor: every result_valid must match the oldest queued frame.
    always @(negedge PCLK) begin
        exp_t e;
        if (frame_err) n_err++;
        if (result_valid) begin
            n_valid++;
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("count",   32'(match_count), 32'(e.cnt));
                chk("x_min",   32'(x_min), 32'(e.xmn));
                chk("x_max",   32'(x_max), 32'(e.xmx));
                chk("y_min",   32'(y_min), 32'(e.ymn));
                chk("y_max",   32'(y_max), 32'(e.ymx));
                chk("detected", 32'(detected), 32'(e.det));
`ifdef FRAME_COLOR_STATS_HIST_EN
                for (int k = 0; k < 8; k++) chk("hist_bin", 32'(hist[k*15 +: 15]), 32'(e.hb[k*15 +: 15]));
`endif
            end
        end
    end

    initial begin
        rst         = 1'b0;
        VSYNC       = 1'b0;
        px_wr       = 1'b0;
        mem_px_addr = '0;
        mem_px_data = '0;
        repeat (4) tick();
        check_reset("por");
        rst = 1'b1;
        repeat (4) tick();

        // Full black frame; VSYNC rises on the final pixel's accept.
        start_frame();
        run_frame(19200, 0, 1, 1'b1, 1'b0, 1'b1);
        repeat (6) tick();
        chk("err_coincident", 32'(n_err), 32'd0);
        chk("valid_after_A", 32'(n_valid), 32'd1);

        // 20x15 red rectangle, frame ended by address.
        start_frame();
        run_frame(7101, 1, 1, 1'b0, 1'b1, 1'b1);
        repeat (6) tick();

        // Strobe held three cycles per pixel; exactly MIN_COUNT reds.
        start_frame();
        run_frame(201, 2, 3, 1'b0, 1'b1, 1'b1);
        repeat (6) tick();

        // One below MIN_COUNT.
        start_frame();
        run_frame(200, 3, 1, 1'b0, 1'b1, 1'b1);
        repeat (6) tick();

        // Aborted frame: outputs must keep the previous frame's values.
        start_frame();
        run_frame(10000, 0, 1, 1'b0, 1'b0, 1'b0);
        VSYNC = 1'b1;
        repeat (6) tick();
        chk("abort_err_pulses", 32'(n_err), 32'd1);
        chk("abort_valid", 32'(n_valid), 32'd4);
        chk("keep_count", 32'(match_count), 32'(last_e.cnt));
        chk("keep_det",   32'(detected), 32'(last_e.det));
        chk("keep_xmax",  32'(x_max), 32'(last_e.xmx));
        chk("keep_ymax",  32'(y_max), 32'(last_e.ymx));

        // Mixed colours after the abort.
        start_frame();
        run_frame(1000, 4, 1, 1'b0, 1'b1, 1'b1);
        repeat (6) tick();

        // Reset mid-frame, then no publish without a fresh VSYNC fall.
        start_frame();
        run_frame(50, 2, 1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_reset("midrst");
        tick();
        rst = 1'b1;
        repeat (3) tick();
        send_px(15'd19199, 3'b100, 1);
        repeat (6) tick();
        chk("midrst_count_kept", 32'(match_count), 32'd0);
        chk("total_valid", 32'(n_valid), 32'd5);
        chk("total_err", 32'(n_err), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
